// File: rtl/sort_loader.sv
// Host-side loader for the bubble-sort engine: writes N words into sort memory, pulses go,
// then streams the sorted readout. Define SORT_LOADER_ORDER_CHECK_EN to add l_order_err.
module sort_loader #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          l_clk,
  input  logic          l_rst_n,
  input  logic          l_in_valid,
  input  logic [W-1:0]  l_in_data,
  output logic          l_in_ready,
  output logic          l_mem_we,
  output logic [AW-1:0] l_mem_addr,
  output logic [W-1:0]  l_mem_wdata,
  output logic          l_go,
  input  logic          l_done,
  input  logic          l_rd_re,
  input  logic [W-1:0]  l_rd_data,
  output logic          l_out_valid,
  output logic [W-1:0]  l_out_data,
  output logic          l_busy,
`ifdef SORT_LOADER_ORDER_CHECK_EN
  output logic          l_order_err,
`endif
  output logic          l_short_err
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_GO,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   in_cnt_reg, in_cnt_next;
  logic [CW-1:0]   out_cnt_reg, out_cnt_next;
  logic            we_reg, we_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [W-1:0]    wdata_reg, wdata_next;
  logic            pending_reg, pending_next;
  logic [W-1:0]    out_data_reg, out_data_next;
  logic            short_err_reg, short_err_next;
  logic            accept;

  assign accept = (state_reg == S_LOAD) && l_in_valid;

  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      state_reg     <= S_LOAD;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      pending_reg   <= 1'b0;
      out_data_reg  <= '0;
      short_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_cnt_reg    <= in_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      pending_reg   <= pending_next;
      out_data_reg  <= out_data_next;
      short_err_reg <= short_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    in_cnt_next    = in_cnt_reg;
    out_cnt_next   = out_cnt_reg;
    we_next        = 1'b0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    pending_next   = 1'b0;
    out_data_next  = out_data_reg;
    short_err_next = short_err_reg;

    unique case (state_reg)
      S_LOAD: begin
        if (accept) begin
          we_next        = 1'b1;
          addr_next      = in_cnt_reg[AW-1:0];
          wdata_next     = l_in_data;
          short_err_next = 1'b0;
          if (in_cnt_reg == LAST) begin
            in_cnt_next = '0;
            state_next  = S_FLUSH;
          end else begin
            in_cnt_next = in_cnt_reg + 1'b1;
          end
        end
      end
      S_FLUSH: state_next = S_GO;
      S_GO:    state_next = S_WAIT;
      S_WAIT: begin
        if (l_done) begin
          out_cnt_next = '0;
          state_next   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The read data for last cycle's re is on the bus now; it is captured regardless of l_done.
        if (pending_reg) begin
          out_data_next = l_rd_data;
          out_cnt_next  = out_cnt_reg + 1'b1;
        end
        if (pending_reg && (out_cnt_reg == LAST)) begin
          state_next = S_LOAD;
        end else if (!l_done && !pending_reg) begin
          state_next     = S_LOAD;
          short_err_next = (out_cnt_reg != FULL);
        end else begin
          pending_next = l_rd_re;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  assign l_in_ready  = (state_reg == S_LOAD);
  assign l_busy      = (state_reg != S_LOAD);
  assign l_go        = (state_reg == S_GO);
  assign l_mem_we    = we_reg;
  assign l_mem_addr  = addr_reg;
  assign l_mem_wdata = wdata_reg;
  assign l_out_valid = pending_reg;
  // Read data is presented in the same cycle it arrives; the register holds it afterwards.
  assign l_out_data  = pending_reg ? l_rd_data : out_data_reg;
  assign l_short_err = short_err_reg;

`ifdef SORT_LOADER_ORDER_CHECK_EN
  logic order_err_reg;
  logic order_hit;

  assign order_hit = pending_reg && (out_cnt_reg != '0) && (l_rd_data < out_data_reg);

  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      order_err_reg <= 1'b0;
    end else if (accept) begin
      order_err_reg <= 1'b0;
    end else if (order_hit) begin
      order_err_reg <= 1'b1;
    end
  end

  assign l_order_err = order_err_reg | order_hit;
`endif

endmodule

// File: tb/tb_sort_loader.sv
// Randomized bench for sort_loader: per-cycle expectation timeline built from the protocol rules,
// one compare process, plus literal checks on the reference job.
module tb_sort_loader;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int NC = 8192;

  logic          l_clk = 1'b0;
  logic          l_rst_n = 1'b0;
  logic          l_in_valid = 1'b0;
  logic [W-1:0]  l_in_data = '0;
  logic          l_in_ready;
  logic          l_mem_we;
  logic [AW-1:0] l_mem_addr;
  logic [W-1:0]  l_mem_wdata;
  logic          l_go;
  logic          l_done = 1'b0;
  logic          l_rd_re = 1'b0;
  logic [W-1:0]  l_rd_data = '0;
  logic          l_out_valid;
  logic [W-1:0]  l_out_data;
  logic          l_busy;
  logic          l_short_err;
`ifdef SORT_LOADER_ORDER_CHECK_EN
  logic          l_order_err;
`endif

  sort_loader #(.N(N), .W(W), .AW(AW)) dut (
    .l_clk(l_clk), .l_rst_n(l_rst_n),
    .l_in_valid(l_in_valid), .l_in_data(l_in_data), .l_in_ready(l_in_ready),
    .l_mem_we(l_mem_we), .l_mem_addr(l_mem_addr), .l_mem_wdata(l_mem_wdata),
    .l_go(l_go), .l_done(l_done), .l_rd_re(l_rd_re), .l_rd_data(l_rd_data),
    .l_out_valid(l_out_valid), .l_out_data(l_out_data), .l_busy(l_busy),
`ifdef SORT_LOADER_ORDER_CHECK_EN
    .l_order_err(l_order_err),
`endif
    .l_short_err(l_short_err)
  );

  always #5 l_clk = ~l_clk;

  int cyc = 0;
  always @(posedge l_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected outputs per cycle index
  bit            e_chk[NC];
  bit            e_rdy[NC];
  bit            e_busy[NC];
  bit            e_short[NC];
  bit            e_go[NC];
  bit            e_we[NC];
  logic [AW-1:0] e_addr[NC];
  logic [W-1:0]  e_wd[NC];
  bit            e_ov[NC];
  logic [W-1:0]  e_od[NC];
  bit            m_short = 1'b0;
`ifdef SORT_LOADER_ORDER_CHECK_EN
  bit            e_order[NC];
  bit            m_order = 1'b0;
  bit            ord_at3 = 1'b0;
  bit            ord_at4 = 1'b1;
`endif

  logic [W-1:0]  job_in[N];
  logic [W-1:0]  job_out[N];
  logic [W-1:0]  out_q[$];
  logic [W-1:0]  mem_img[1<<AW];
  int            go_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge l_clk);
    #1;
  endtask

  task automatic set_exp(input bit load);
    e_chk[cyc]   = 1'b1;
    e_rdy[cyc]   = load;
    e_busy[cyc]  = !load;
    e_short[cyc] = m_short;
`ifdef SORT_LOADER_ORDER_CHECK_EN
    e_order[cyc] = m_order;
`endif
  endtask

  always @(negedge l_clk) begin
    if (cyc < NC && e_chk[cyc]) begin
      chk("in_ready", l_in_ready, e_rdy[cyc]);
      chk("busy", l_busy, e_busy[cyc]);
      chk("short_err", l_short_err, e_short[cyc]);
      chk("go", l_go, e_go[cyc]);
      chk("mem_we", l_mem_we, e_we[cyc]);
      if (e_we[cyc]) begin
        chk("mem_addr", l_mem_addr, e_addr[cyc]);
        chk("mem_wdata", l_mem_wdata, e_wd[cyc]);
      end
      chk("out_valid", l_out_valid, e_ov[cyc]);
      if (e_ov[cyc]) chk("out_data", l_out_data, e_od[cyc]);
`ifdef SORT_LOADER_ORDER_CHECK_EN
      chk("order_err", l_order_err, e_order[cyc]);
`endif
    end
  end

  // Observers feeding the literal checks
  always @(negedge l_clk) begin
    if (l_out_valid) out_q.push_back(l_out_data);
    if (l_mem_we) mem_img[l_mem_addr] = l_mem_wdata;
    if (l_go) go_cyc = cyc;
`ifdef SORT_LOADER_ORDER_CHECK_EN
    if (l_out_valid && l_out_data == 8'd3) ord_at3 = l_order_err;
    if (l_out_valid && l_out_data == 8'd4) ord_at4 = l_order_err;
`endif
  end

  // Accept words kstart..kend-1 with the given valid probability; a full load continues through FLUSH and GO.
  task automatic load_job(input int kstart, input int kend, input int pct, output int t_last);
    int k;
    bit v;
    k = kstart;
    t_last = -1;
    while (k < kend) begin
      v = ($urandom_range(99) < pct);
      l_done = 1'b0;
      l_rd_re = 1'b0;
      l_rd_data = W'($urandom);
      l_in_valid = v;
      l_in_data = v ? job_in[k] : W'($urandom);
      set_exp(1'b1);
      if (v) begin
        e_we[cyc+1] = 1'b1;
        e_addr[cyc+1] = AW'(k);
        e_wd[cyc+1] = job_in[k];
        m_short = 1'b0;
`ifdef SORT_LOADER_ORDER_CHECK_EN
        m_order = 1'b0;
`endif
        t_last = cyc;
        k++;
      end
      step();
    end
    if (kend == N) begin
      l_in_valid = 1'b1;
      l_in_data = W'($urandom);
      set_exp(1'b0);
      step();
      l_in_valid = ($urandom_range(1) != 0);
      set_exp(1'b0);
      e_go[cyc] = 1'b1;
      step();
    end
  endtask

  // Controller sorting: done low for n cycles (optionally with stray re and held valid), then done rises.
  task automatic wait_sort(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      l_done = 1'b0;
      l_in_valid = noisy;
      l_in_data = W'($urandom);
      l_rd_re = noisy ? ($urandom_range(1) != 0) : 1'b0;
      l_rd_data = W'($urandom);
      set_exp(1'b0);
      step();
    end
    l_done = 1'b1;
    l_rd_re = 1'b0;
    set_exp(1'b0);
    step();
  endtask

  // Controller readout: issue nreads reads of job_out, then either finish (nreads==N) or drop done.
  task automatic drain(input int nreads);
    int issued;
    int got;
    bit pend;
    bit cap;
    bit fin;
    logic [W-1:0] pval;
`ifdef SORT_LOADER_ORDER_CHECK_EN
    logic [W-1:0] last_emit;
    last_emit = '0;
`endif
    issued = 0;
    got = 0;
    pend = 1'b0;
    fin = 1'b0;
    pval = '0;
    for (int guard = 0; guard < 200 && !fin; guard++) begin
      cap = pend;
      pend = 1'b0;
      set_exp(1'b0);
      l_in_valid = ($urandom_range(1) != 0);
      l_in_data = W'($urandom);
      if (cap) begin
        l_rd_data = pval;
        e_ov[cyc] = 1'b1;
        e_od[cyc] = pval;
`ifdef SORT_LOADER_ORDER_CHECK_EN
        if (got > 0 && pval < last_emit) m_order = 1'b1;
        last_emit = pval;
        e_order[cyc] = m_order;
`endif
        got++;
      end else begin
        l_rd_data = W'($urandom);
      end
      if (cap && got == N) begin
        l_done = 1'b1;
        l_rd_re = 1'b0;
        fin = 1'b1;
      end else if (issued < nreads) begin
        l_done = 1'b1;
        l_rd_re = ($urandom_range(2) != 0);
        if (l_rd_re) begin
          pval = job_out[issued];
          issued++;
          pend = 1'b1;
        end
      end else begin
        l_done = 1'b0;
        l_rd_re = 1'b0;
        if (!cap) begin
          m_short = (got < N);
          fin = 1'b1;
        end
      end
      step();
    end
    if (!fin) chk("drain_finished", 0, 1);
    l_done = 1'b0;
    l_rd_re = 1'b0;
    l_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    l_rst_n = 1'b0;
    l_in_valid = 1'b0;
    l_done = 1'b0;
    l_rd_re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_we[cyc+i] = 1'b0;
      e_go[cyc+i] = 1'b0;
      e_ov[cyc+i] = 1'b0;
    end
    m_short = 1'b0;
`ifdef SORT_LOADER_ORDER_CHECK_EN
    m_order = 1'b0;
`endif
    set_exp(1'b1);
    @(negedge l_clk);
    chk("rst_mem_addr", l_mem_addr, 0);
    chk("rst_mem_wdata", l_mem_wdata, 0);
    chk("rst_out_data", l_out_data, 0);
    step();
    set_exp(1'b1);
    step();
    l_rst_n = 1'b1;
  endtask

  task automatic rand_job_data();
    for (int i = 0; i < N; i++) begin
      job_in[i] = W'($urandom);
      job_out[i] = W'($urandom);
    end
  endtask

  initial begin
    #(NC * 10);
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t_last;
    logic [W-1:0] ref_in[N];
    step();
    do_reset();

    // Reference job: 5,3,7,1,8,2,6,4 back-to-back, readout 1..8
    ref_in = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    for (int i = 0; i < N; i++) begin
      job_in[i] = ref_in[i];
      job_out[i] = W'(i + 1);
    end
    load_job(0, N, 100, t_last);
    chk("go_at_tlast_plus2", go_cyc, t_last + 2);
    for (int i = 0; i < N; i++) chk("mem_image", mem_img[i], ref_in[i]);
    wait_sort(5, 1'b0);
    out_q.delete();
    drain(N);
    @(negedge l_clk);
    chk("ref_out_count", out_q.size(), N);
    for (int i = 0; i < N && i < out_q.size(); i++) chk("ref_out_word", out_q[i], i + 1);
    chk("busy_after_ref", l_busy, 0);

    // Short readout: done drops after 5 reads
    rand_job_data();
    load_job(0, N, 70, t_last);
    wait_sort($urandom_range(10, 3), 1'b0);
    out_q.delete();
    drain(5);
    @(negedge l_clk);
    chk("short_out_count", out_q.size(), 5);
    chk("short_err_set", l_short_err, 1);
    chk("short_back_to_load", l_in_ready, 1);

    // Next job: first accept clears short_err; noisy WAIT phase
    rand_job_data();
    load_job(0, 1, 100, t_last);
    @(negedge l_clk);
    chk("short_err_cleared", l_short_err, 0);
    load_job(1, N, 80, t_last);
    wait_sort(12, 1'b1);
    drain(N);

    // Reset mid-load after 3 words, then a fresh full job
    rand_job_data();
    load_job(0, 3, 100, t_last);
    do_reset();
    rand_job_data();
    load_job(0, N, 100, t_last);
    wait_sort($urandom_range(8, 1), 1'b1);
    drain(N);

    // Out-of-order readout 1,2,4,3,5,6,7,8
    rand_job_data();
    job_out = '{8'd1, 8'd2, 8'd4, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8};
    load_job(0, N, 90, t_last);
    wait_sort(4, 1'b0);
    drain(N);
`ifdef SORT_LOADER_ORDER_CHECK_EN
    chk("order_err_before_3", ord_at4, 0);
    chk("order_err_at_3", ord_at3, 1);
`endif

    // Randomized jobs, mixing full and truncated readouts
    repeat (8) begin
      rand_job_data();
      load_job(0, N, $urandom_range(100, 40), t_last);
      wait_sort($urandom_range(15, 1), ($urandom_range(1) != 0));
      drain(($urandom_range(1) != 0) ? N : $urandom_range(N - 1, 0));
    end

    l_in_valid = 1'b0;
    set_exp(1'b1);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_loader.md
# sort_loader

Host-side front/back end for the bubble-sort engine. Accepts N unsorted words on a valid/ready stream, writes them into the sort memory at addresses 0..N-1, and issues a one-cycle `go` to the sort controller. During the controller's done phase it captures the sorted words from the memory read bus and emits them as an output stream. It is the writer/initiator on one side of the sort controller's `go`/`done`/`re` interface, and the reader of its sorted output.

## Interface
Parameters:
- `N`, 8, number of words per sort job (≥2)
- `W`, 8, data width
- `AW`, 3, memory address width (2^AW ≥ N)

Ports:
- `l_clk`  in  1  clock, rising edge
- `l_rst_n`  in  1  reset, asynchronous, active-low
- `l_in_valid`  in  1  input word valid
- `l_in_data`  in  W  input word
- `l_in_ready`  out  1  loader can accept a word
- `l_mem_we`  out  1  sort-memory write strobe
- `l_mem_addr`  out  AW  sort-memory write address
- `l_mem_wdata`  out  W  sort-memory write data
- `l_go`  out  1  start pulse to the sort controller
- `l_done`  in  1  controller done phase (sorted readout active)
- `l_rd_re`  in  1  controller memory read enable
- `l_rd_data`  in  W  memory read data, valid 1 cycle after `l_rd_re`
- `l_out_valid`  out  1  sorted word valid (single-cycle, no backpressure)
- `l_out_data`  out  W  sorted word
- `l_busy`  out  1  high in every state except LOAD
- `l_short_err`  out  1  sticky: done phase ended before N words were read

## Operation
- States: LOAD, FLUSH, GO, WAIT, DRAIN.
- LOAD: `l_in_ready`=1. A handshake (valid&ready) at word index k registers `l_mem_we`=1, `l_mem_addr`=k, `l_mem_wdata`=data for the next cycle. The index counter increments. On the N-th accept the block moves to FLUSH.
- FLUSH: the last write issues. `l_in_ready`=0. Next state GO.
- GO: `l_go`=1 for exactly one cycle. Next state WAIT.
- WAIT: `l_rd_re` pulses during sorting are ignored. On `l_done`=1 the block clears the output counter and moves to DRAIN.
- DRAIN: each cycle with `l_rd_re`=1 sets a pending flag. The next cycle loads `l_rd_data` into `l_out_data`, pulses `l_out_valid`, and increments the output count.
- Exit from DRAIN to LOAD:
  - when the output count reaches N, or
  - when `l_done` falls with no capture pending. If the count is below N, `l_short_err` is set.
- A pending capture always completes, even if `l_done` falls in the same cycle.
- `l_short_err` clears on the first accepted word of the next job.
- `l_done` seen in LOAD/FLUSH/GO is ignored. `l_in_valid` outside LOAD is ignored (`l_in_ready`=0).
- Counters are AW+1 bits wide and compare against N exactly. No wrap occurs within a job.

## Timing
- Reset (async assert, sync release) values:
  - state=LOAD
  - `l_in_ready`=1 (decoded from state)
  - `l_mem_we`, `l_go`, `l_out_valid`, `l_busy`, `l_short_err`=0
  - `l_mem_addr`, `l_mem_wdata`, `l_out_data`=0
  - all counters 0
- Reset mid-job abandons the job immediately. No `go` or output is produced.
- Write latency: accept at cycle t → `l_mem_we` at t+1.
- Last accept at t → FLUSH write at t+1 → `l_go` at t+2 → WAIT from t+3.
- Read latency: `l_rd_re` sampled at cycle t → `l_out_valid` with data at t+1.
- Minimum job length: N accept cycles + 2 + controller sort time + drain.

## Configuration
- `SORT_LOADER_ORDER_CHECK_EN` defined:
  - Adds output `l_order_err` (1 bit, reset 0).
  - During DRAIN, each emitted word after the first is compared, unsigned, with the previous emitted word. If it is smaller, `l_order_err` sets and stays set (sticky) until the first accept of the next job.
- Not defined: the port and the comparison logic are absent.

## Test plan
- Reset then load 5,3,7,1,8,2,6,4 back-to-back with `l_in_valid`=1 → eight writes, addr 0..7 carrying the same data in the cycle after each accept; `l_go` one cycle at t_last+2; `l_in_ready`=0 from FLUSH on.
- Same job with a controller model that asserts `l_done` and 8 `l_rd_re` pulses returning 1..8 → eight `l_out_valid` pulses with 1,2,…,8, each one cycle after its re; return to LOAD; `l_busy`=0.
- Model drops `l_done` after 5 reads → 5 outputs, `l_short_err`=1, state LOAD. Next accepted word clears `l_short_err`.
- `l_rd_re` pulses in WAIT with `l_done`=0, and `l_in_valid`=1 held through WAIT → no `l_out_valid`, no `l_mem_we`.
- Assert `l_rst_n`=0 mid-load after 3 words, then release → all outputs at reset values; a fresh 8-word load restarts writes at addr 0.
- With `SORT_LOADER_ORDER_CHECK_EN`: drain 1,2,4,3,… → `l_order_err`=1 from the cycle 3 is emitted; without the macro the port does not exist.
